// File: rtl/sipo_rx_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_rx_ctrl
//
// Sequencing controller for a DW-bit serial-in/parallel-out shift register
// (MSB-in, shift-right). A start strobe frames a word. Per-bit valid strobes
// gate the SIPO shift enable. After exactly DW accepted bits, the SIPO parallel
// output is captured into a holding register. That register is offered
// downstream on a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start_i     begin a new word (sampled only in IDLE)
//   bit_vld_i   serial bit present on the SIPO input this cycle
//   sipo_out_i  parallel output of the controlled SIPO
//   sft_enb_o   shift enable to the SIPO
//   data_o      captured word
//   data_vld_o  data_o holds an unconsumed word
//   data_rdy_i  downstream accepts data_o
//   busy_o      a word is being assembled or captured
//   bit_cnt_o   bits accepted so far in the current word
//   ovf_o       sticky flag: a completed word was dropped
//   ovf_clr_i   synchronous clear of ovf_o (a new overflow wins)
// -----------------------------------------------------------------------------
module sipo_rx_ctrl #(
  parameter  int DW = 4,
  localparam int CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          bit_vld_i,
  input  logic [DW-1:0] sipo_out_i,
  output logic          sft_enb_o,
  output logic [DW-1:0] data_o,
  output logic          data_vld_o,
  input  logic          data_rdy_i,
  output logic          busy_o,
  output logic [CW-1:0] bit_cnt_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] data_q;
  logic          data_vld_q;
  logic          ovf_q;

  // The shift enable must follow bit_vld_i in the same cycle, because the SIPO
  // samples the serial bit on the same edge. Only that path is combinational.
  // busy is a pure state decode.
  assign sft_enb_o  = (state == SHIFT) && bit_vld_i;
  assign busy_o     = (state != IDLE);
  assign bit_cnt_o  = bit_cnt;
  assign data_o     = data_q;
  assign data_vld_o = data_vld_q;
  assign ovf_o      = ovf_q;

  // NOTE: all state below uses non-blocking assignments, so every register
  // samples pre-edge values and the decisions in one block do not race.
  // NOTE: the holding register is reset together with the control state, so
  // data_o reads zero after reset instead of holding a stale word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // A downstream transfer empties the holding register. A capture below
      // may refill it on the same edge.
      if (data_vld_q && data_rdy_i) begin
        data_vld_q <= 1'b0;
      end

      // Clearing has lower priority: a capture-time overflow overrides it.
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_i) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end

        SHIFT: begin
          if (bit_vld_i) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= CAPT;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        CAPT: begin
          state <= IDLE;
          // The word can load if the register is empty, or if its old content
          // leaves on this same edge. Otherwise the new word is dropped.
          if (!data_vld_q || data_rdy_i) begin
            data_q     <= sipo_out_i;
            data_vld_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx_ctrl
//
// Directed bench for sipo_rx_ctrl with DW=4. A behavioural SIPO (MSB-in,
// shift-right) is driven by the DUT's sft_enb_o. The SIPO's output feeds
// sipo_out_i. Inputs change 1 time unit after each rising edge, and outputs
// are observed before the next edge.
// -----------------------------------------------------------------------------
module tb_sipo_rx_ctrl;

  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          bit_vld_i;
  logic [DW-1:0] sipo_out_i;
  logic          sft_enb_o;
  logic [DW-1:0] data_o;
  logic          data_vld_o;
  logic          data_rdy_i;
  logic          busy_o;
  logic [CW-1:0] bit_cnt_o;
  logic          ovf_o;
  logic          ovf_clr_i;

  logic          ser_bit;
  int            total = 0;
  int            bad   = 0;
  int            enb_cnt  = 0;
  int            xfer_cnt = 0;
  int            enb_base;
  int            xfer_base;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .bit_vld_i  (bit_vld_i),
    .sipo_out_i (sipo_out_i),
    .sft_enb_o  (sft_enb_o),
    .data_o     (data_o),
    .data_vld_o (data_vld_o),
    .data_rdy_i (data_rdy_i),
    .busy_o     (busy_o),
    .bit_cnt_o  (bit_cnt_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  // Controlled SIPO: new bit enters at the MSB, so the first bit ends in [0].
  always @(posedge clk or negedge rst) begin
    if (!rst) sipo_out_i <= '0;
    else if (sft_enb_o) sipo_out_i <= {ser_bit, sipo_out_i[DW-1:1]};
  end

  // Edge counters for shift enables and handshake transfers.
  always @(posedge clk) begin
    if (sft_enb_o) enb_cnt <= enb_cnt + 1;
    if (data_vld_o && data_rdy_i) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frames one word. The task returns in the CAPT cycle, just after the edge
  // that accepted the last bit. The caller decides what happens on the
  // capture edge.
  //   var_gap        : insert i idle cycles before bit i
  //   vld_with_start : raise bit_vld_i together with start_i (must not shift)
  //   hold_start     : keep start_i high through SHIFT and CAPT
  task automatic send_word(input logic [DW-1:0] w, input bit var_gap,
                           input bit vld_with_start, input bit hold_start);
    start_i   = 1'b1;
    bit_vld_i = vld_with_start;
    ser_bit   = 1'b1;
    #1;
    if (vld_with_start) check("idle_gates_enb", sft_enb_o, 1'b0);
    tick();
    for (int i = 0; i < DW; i++) begin
      start_i   = hold_start;
      bit_vld_i = 1'b0;
      if (var_gap) begin
        for (int g = 0; g < i; g++) begin
          #1;
          check("gap_cnt_hold", bit_cnt_o, i);
          check("gap_enb_low", sft_enb_o, 1'b0);
          tick();
        end
      end
      bit_vld_i = 1'b1;
      ser_bit   = w[i];
      #1;
      check("shift_enb", sft_enb_o, 1'b1);
      check("shift_cnt", bit_cnt_o, i);
      tick();
    end
    bit_vld_i = 1'b0;
    #1;
    check("capt_busy", busy_o, 1'b1);
    check("capt_enb", sft_enb_o, 1'b0);
    check("capt_cnt", bit_cnt_o, 0);
  endtask

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    bit_vld_i  = 1'b0;
    ser_bit    = 1'b0;
    data_rdy_i = 1'b1;
    ovf_clr_i  = 1'b0;
    #2;
    check("rst_data", data_o, 0);
    check("rst_vld", data_vld_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", bit_cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_enb", sft_enb_o, 0);
    tick();
    rst = 1'b1;
    tick();

    // 1) Back-to-back bits 1,0,1,1 -> 4'hD, ready high.
    enb_base = enb_cnt;
    send_word(4'hD, 1'b0, 1'b0, 1'b0);
    check("w1_vld_before", data_vld_o, 0);
    tick();
    check("w1_data", data_o, 4'hD);
    check("w1_vld", data_vld_o, 1);
    check("w1_busy", busy_o, 0);
    check("w1_enb_cycles", enb_cnt - enb_base, 4);
    tick();
    check("w1_vld_one_cycle", data_vld_o, 0);

    // 2) Variable gaps, and bit_vld_i together with start_i (not shifted).
    enb_base = enb_cnt;
    send_word(4'hD, 1'b1, 1'b1, 1'b0);
    tick();
    check("w2_data", data_o, 4'hD);
    check("w2_vld", data_vld_o, 1);
    check("w2_enb_cycles", enb_cnt - enb_base, 4);
    tick();

    // 3) Ready low: 4'hA is held, 4'h5 is dropped and overflow is flagged.
    data_rdy_i = 1'b0;
    send_word(4'hA, 1'b0, 1'b0, 1'b0);
    tick();
    check("w3a_data", data_o, 4'hA);
    check("w3a_vld", data_vld_o, 1);
    check("w3a_ovf", ovf_o, 0);
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    check("w3b_data_kept", data_o, 4'hA);
    check("w3b_vld", data_vld_o, 1);
    check("w3b_ovf", ovf_o, 1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("w3_ovf_clr", ovf_o, 0);
    check("w3_data_stable", data_o, 4'hA);
    xfer_base  = xfer_cnt;
    data_rdy_i = 1'b1;
    tick();
    check("w3_xfer_vld", data_vld_o, 0);
    check("w3_xfer_cnt", xfer_cnt - xfer_base, 1);

    // 4) Register holds 4'h3. 4'hC captures while ready is high on the capture edge.
    data_rdy_i = 1'b0;
    send_word(4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    check("w4a_data", data_o, 4'h3);
    send_word(4'hC, 1'b0, 1'b0, 1'b0);
    xfer_base  = xfer_cnt;
    data_rdy_i = 1'b1;
    tick();
    check("w4_data_new", data_o, 4'hC);
    check("w4_vld_stays", data_vld_o, 1);
    check("w4_ovf", ovf_o, 0);
    check("w4_old_xfer", xfer_cnt - xfer_base, 1);
    tick();
    check("w4_drain", data_vld_o, 0);

    // 5) Reset after 2 of 4 bits, then a clean 4'h6.
    start_i = 1'b1;
    tick();
    start_i   = 1'b0;
    bit_vld_i = 1'b1;
    ser_bit   = 1'b1;
    tick();
    ser_bit = 1'b0;
    tick();
    check("w5_mid_cnt", bit_cnt_o, 2);
    rst = 1'b0;
    #1;
    check("w5_rst_cnt", bit_cnt_o, 0);
    check("w5_rst_busy", busy_o, 0);
    check("w5_rst_enb", sft_enb_o, 0);
    check("w5_rst_data", data_o, 0);
    check("w5_rst_vld", data_vld_o, 0);
    check("w5_rst_ovf", ovf_o, 0);
    check("w5_rst_sipo", sipo_out_i, 0);
    bit_vld_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send_word(4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    check("w5_data", data_o, 4'h6);
    check("w5_vld", data_vld_o, 1);
    tick();

    // 6) start_i held through SHIFT and CAPT gives exactly one word.
    xfer_base = xfer_cnt;
    send_word(4'h9, 1'b0, 1'b0, 1'b1);
    tick();
    start_i = 1'b0;
    check("w6_busy_idle", busy_o, 0);
    check("w6_data", data_o, 4'h9);
    tick();
    tick();
    check("w6_still_idle", busy_o, 0);
    check("w6_one_word", xfer_cnt - xfer_base, 1);

    // Clear coinciding with an overflow: set wins.
    data_rdy_i = 1'b0;
    send_word(4'hB, 1'b0, 1'b0, 1'b0);
    tick();
    send_word(4'h2, 1'b0, 1'b0, 1'b0);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("w6_ovf_set_wins", ovf_o, 1);
    check("w6_data_kept", data_o, 4'hB);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("w6_ovf_cleared", ovf_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Sequencing controller for the DW-bit serial-in/parallel-out shift register (MSB-in, shift-right).
- Frames a serial word on a start strobe and gates the SIPO shift enable with per-bit valid strobes.
- Counts exactly DW accepted bits, then captures the SIPO parallel output into a holding register.
- Presents the held word downstream on a valid/ready handshake, with a sticky overflow flag for words lost because the holding register was still occupied.

Parameters:
- DW, 4, word width; must match the controlled SIPO; legal values ≥ 2.
- CW, $clog2(DW), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  begin a new word; sampled only in IDLE.
- bit_vld_i  input  1  serial bit present on the SIPO inp this cycle.
- sipo_out_i  input  DW  parallel output of the controlled SIPO.
- sft_enb_o  output  1  drives the SIPO enb.
- data_o  output  DW  captured word.
- data_vld_o  output  1  data_o holds an unconsumed word.
- data_rdy_i  input  1  downstream accepts data_o.
- busy_o  output  1  high in SHIFT or CAPT.
- bit_cnt_o  output  CW  number of bits accepted in the current word.
- ovf_o  output  1  sticky overflow flag.
- ovf_clr_i  input  1  synchronous clear of ovf_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - bit_cnt_o=0, data_o=0, data_vld_o=0, ovf_o=0.
  - sft_enb_o=0 and busy_o=0, since both are decoded from state.
- FSM states: IDLE, SHIFT, CAPT.
- IDLE:
  - sft_enb_o=0; bit_vld_i is ignored.
  - start_i=1 → SHIFT at the next edge, with bit_cnt cleared to 0.
  - A bit_vld_i asserted in the same cycle as start_i is NOT shifted.
- SHIFT:
  - sft_enb_o = bit_vld_i (combinational). Every accepted bit increments bit_cnt.
  - On the edge accepting a bit with bit_cnt==DW-1: state → CAPT and bit_cnt → 0.
  - start_i is ignored. There is no timeout; gaps between bits are unbounded.
- CAPT (exactly one cycle):
  - sft_enb_o=0; the SIPO now holds the full word.
  - At the next edge: data_o ← sipo_out_i, state → IDLE.
  - start_i asserted during CAPT is ignored. Minimum inter-word gap is one IDLE cycle.
- Latency: data_vld_o rises at the edge one cycle after the edge that accepted the last bit.
- Bit order: the first bit received lands in data_o[0]; the last bit received lands in data_o[DW-1].
- Handshake:
  - A transfer occurs on an edge where data_vld_o & data_rdy_i; data_vld_o then clears.
  - data_o stays stable while data_vld_o=1 and not transferred.
  - data_rdy_i is don't-care while data_vld_o=0.
- Capture with the holding register occupied (CAPT edge, data_vld_o=1):
  - If data_rdy_i=1: the old word transfers, the new word loads, data_vld_o stays 1, no overflow.
  - If data_rdy_i=0: the new word is dropped, data_o and data_vld_o are unchanged, ovf_o ← 1.
- ovf_o:
  - Sticky; cleared only by ovf_clr_i or reset.
  - If ovf_clr_i coincides with a new overflow event, set wins (ovf_o=1).
- Reset asserted mid-word: returns to IDLE immediately and the partial word is discarded. The SIPO is reset by the same rst.
- busy_o=1 in SHIFT and CAPT.

Test Plan:
- DW=4; pulse start_i; send bits 1,0,1,1 (first→last) on consecutive cycles with data_rdy_i=1 → sft_enb_o high for exactly 4 cycles; data_o=4'hD; data_vld_o high for 1 cycle, one cycle after the last bit; busy_o back to 0.
- Same word with 0–3 idle cycles between bit_vld_i pulses; start_i and bit_vld_i asserted together → the first bit is not shifted, 4 later bits are counted; bit_cnt_o steps 0,1,2,3,0; data_o is correct.
- data_rdy_i=0; receive 4'hA then 4'h5 → data_o stays 4'hA with data_vld_o=1; ovf_o=1 after the second capture; pulse ovf_clr_i → ovf_o=0; raise data_rdy_i → transfer 4'hA.
- Holding register full (4'h3), second word 4'hC completes with data_rdy_i=1 on the CAPT edge → 4'h3 transfers, data_o=4'hC, data_vld_o stays 1, ovf_o=0.
- Drop rst after 2 of 4 bits → all outputs are 0 asynchronously. Release rst, start a new word 4'h6 → data_o=4'h6 with no residue.
- start_i pulsed during SHIFT and CAPT → ignored; a single word is produced. ovf_clr_i coincident with an overflow → ovf_o=1.
